// File: rtl/rtc_count_latch.sv
// rtc_count_latch: prescaled BCD stopwatch (MM:SS.hh) with a display-holding latch.
// The live count runs from i_count_enb/i_count_init. The latched copy is what the
// display side reads, and it is refreshed only by i_latch_count.
// Build option: define RTC_SATURATE_EN to hold at 59:59.99 instead of wrapping.
module rtc_count_latch #(
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned PRESC_W  = 16
) (
    input  logic       i_sclk,
    input  logic       i_reset,
    input  logic       i_count_init,
    input  logic       i_count_enb,
    input  logic       i_latch_count,
    output logic [7:0] o_hund,
    output logic [7:0] o_sec,
    output logic [7:0] o_min,
    output logic       o_latch_valid,
    output logic       o_overflow,
    output logic       o_running
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    // Live count packed as {min, sec, hund}, two BCD digits per field.
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [23:0]        live_q,  live_d;
    logic [23:0]        lat_q,   lat_d;
    logic               vld_q,   vld_d;
    logic               ovf_q,   ovf_d;
    logic               run_q,   run_d;

    logic [8:0]         hund_inc;
    logic [8:0]         sec_inc;
    logic [8:0]         min_inc;
    logic [23:0]        chain_next;
    logic               wrap;
    logic               frozen;
    logic               advance;
    logic               tick;

    // One BCD digit step: returns {carry, next}; wraps to 0 after 'last'.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d, input logic [3:0] last);
        if (d == last) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

    // Two-digit BCD field step (units always 0..9, tens 0..tens_last).
    // Returns {carry_out, tens, units}.
    function automatic logic [8:0] bcd_pair_inc(input logic [7:0] v, input logic [3:0] tens_last);
        logic [4:0] u;
        logic [4:0] t;
        u = bcd_digit_inc(v[3:0], 4'd9);
        if (u[4]) begin
            t = bcd_digit_inc(v[7:4], tens_last);
        end else begin
            t = {1'b0, v[7:4]};
        end
        return {t[4], t[3:0], u[3:0]};
    endfunction

    // Carry chain: each field advances only when every lower field rolls over.
    always_comb begin
        hund_inc   = bcd_pair_inc(live_q[7:0],   4'd9);
        sec_inc    = bcd_pair_inc(live_q[15:8],  4'd5);
        min_inc    = bcd_pair_inc(live_q[23:16], 4'd5);
        chain_next = live_q;
        chain_next[7:0] = hund_inc[7:0];
        if (hund_inc[8]) begin
            chain_next[15:8] = sec_inc[7:0];
        end
        if (hund_inc[8] && sec_inc[8]) begin
            chain_next[23:16] = min_inc[7:0];
        end
        // All three fields carrying out means the count sits at 59:59.99.
        wrap = hund_inc[8] & sec_inc[8] & min_inc[8];
    end

    // Tick generation; init always wins over enable.
    always_comb begin
`ifdef RTC_SATURATE_EN
        // Once the overflow tick has been absorbed at max, stop the prescaler too.
        frozen = wrap & ovf_q;
`else
        frozen = 1'b0;
`endif
        advance = i_count_enb & ~i_count_init & ~frozen;
        tick    = advance & (presc_q == PRESC_LAST);
    end

    // Next-state for prescaler, live count, overflow, latch and status.
    always_comb begin
        presc_d = presc_q;
        live_d  = live_q;
        ovf_d   = ovf_q;
        if (i_count_init) begin
            presc_d = '0;
            live_d  = '0;
            ovf_d   = 1'b0;
        end else if (advance) begin
            if (tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
            if (tick) begin
                if (wrap) begin
                    ovf_d = 1'b1;
`ifdef RTC_SATURATE_EN
                    live_d = live_q;
`else
                    live_d = chain_next;
`endif
                end else begin
                    live_d = chain_next;
                end
            end
        end

        // Capture uses the pre-edge live value, so latch+init and latch+tick
        // both see the count as it stood before this edge's update.
        lat_d = i_latch_count ? live_q : lat_q;
        vld_d = i_latch_count;
        run_d = i_count_enb & ~i_count_init;
    end

    // Prescaler and live count registers.
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            presc_q <= '0;
            live_q  <= '0;
        end else begin
            presc_q <= presc_d;
            live_q  <= live_d;
        end
    end

    // Display-holding latch and its one-cycle valid pulse.
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            lat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            lat_q <= lat_d;
            vld_q <= vld_d;
        end
    end

    // Sticky overflow flag and running status.
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            ovf_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            run_q <= run_d;
        end
    end

    assign o_hund        = lat_q[7:0];
    assign o_sec         = lat_q[15:8];
    assign o_min         = lat_q[23:16];
    assign o_latch_valid = vld_q;
    assign o_overflow    = ovf_q;
    assign o_running     = run_q;

endmodule
